// File: rtl/hdmi_pkg.sv
// hdmi_pkg: 720p60 timing defaults, YCbCr constants, colour-bar table and pattern encodings
package hdmi_pkg;

  localparam int H_ACT_720  = 1280;
  localparam int H_FP_720   = 110;
  localparam int H_SYNC_720 = 40;
  localparam int H_BP_720   = 220;
  localparam int V_ACT_720  = 720;
  localparam int V_FP_720   = 5;
  localparam int V_SYNC_720 = 5;
  localparam int V_BP_720   = 20;

  localparam logic [15:0] YCC_BLANK = 16'h1080;
  localparam logic [15:0] YCC_WHITE = 16'hEB80;
  localparam logic [7:0]  C_NEUTRAL = 8'h80;

  typedef enum logic [1:0] {
    PAT_PASS  = 2'd0,
    PAT_BARS  = 2'd1,
    PAT_RAMP  = 2'd2,
    PAT_WHITE = 2'd3
  } pat_e;

  typedef struct packed {
    logic [7:0] y;
    logic [7:0] cb;
    logic [7:0] cr;
  } ycc_t;

  // 75% bars, left to right: white, yellow, cyan, green, magenta, red, blue, black
  localparam logic [0:7][23:0] BAR_TAB = {
    24'hB48080, 24'hA82C88, 24'h91932C, 24'h853F34,
    24'h3FC1CC, 24'h336DD4, 24'h1CD478, 24'h108080
  };

  function automatic ycc_t bar_ycc(input logic [2:0] idx);
    return ycc_t'(BAR_TAB[idx]);
  endfunction

endpackage

// File: rtl/hdmi_vtg.sv
// hdmi_vtg: free-running h/v counters with combinational active, sync and frame-origin decode
module hdmi_vtg #(
  parameter int H_ACT    = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACT    = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter int SYNC_POL = 1,
  parameter int HW       = $clog2(H_ACT + H_FP + H_SYNC + H_BP),
  parameter int VW       = $clog2(V_ACT + V_FP + V_SYNC + V_BP)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  output logic [HW-1:0] h_cnt_o,
  output logic          active_o,
  output logic          hsync_o,
  output logic          vsync_o,
  output logic          origin_o
);

  localparam logic [HW-1:0] H_LAST  = HW'(H_ACT + H_FP + H_SYNC + H_BP - 1);
  localparam logic [HW-1:0] H_ACT_C = HW'(H_ACT);
  localparam logic [HW-1:0] HS_BEG  = HW'(H_ACT + H_FP);
  localparam logic [HW-1:0] HS_END  = HW'(H_ACT + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST  = VW'(V_ACT + V_FP + V_SYNC + V_BP - 1);
  localparam logic [VW-1:0] V_ACT_C = VW'(V_ACT);
  localparam logic [VW-1:0] VS_BEG  = VW'(V_ACT + V_FP);
  localparam logic [VW-1:0] VS_END  = VW'(V_ACT + V_FP + V_SYNC);
  localparam logic          POL     = SYNC_POL != 0;

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic          h_wrap;

  always_comb begin
    h_wrap  = h_cnt_q == H_LAST;
    h_cnt_d = h_wrap ? '0 : h_cnt_q + HW'(1);
    v_cnt_d = !h_wrap ? v_cnt_q : (v_cnt_q == V_LAST) ? '0 : v_cnt_q + VW'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  // v_cnt only moves on the h wrap, so vsync can only change at h_cnt=0
  assign h_cnt_o  = h_cnt_q;
  assign active_o = (h_cnt_q < H_ACT_C) && (v_cnt_q < V_ACT_C);
  assign hsync_o  = (h_cnt_q >= HS_BEG && h_cnt_q < HS_END) ? POL : !POL;
  assign vsync_o  = (v_cnt_q >= VS_BEG && v_cnt_q < VS_END) ? POL : !POL;
  assign origin_o = (h_cnt_q == '0) && (v_cnt_q == '0);

endmodule

// File: rtl/hdmi_pattern_gen.sv
// hdmi_pattern_gen: HDMI output stage; registered PS video pass-through or
// locally timed YCbCr 4:2:2 test patterns, mode switched only at frame origin
module hdmi_pattern_gen
  import hdmi_pkg::*;
#(
  parameter int H_ACT    = H_ACT_720,
  parameter int H_FP     = H_FP_720,
  parameter int H_SYNC   = H_SYNC_720,
  parameter int H_BP     = H_BP_720,
  parameter int V_ACT    = V_ACT_720,
  parameter int V_FP     = V_FP_720,
  parameter int V_SYNC   = V_SYNC_720,
  parameter int V_BP     = V_BP_720,
  parameter int SYNC_POL = 1
) (
  input  logic        hdmi_clk,
  input  logic        hdmi_rst,
  input  logic [1:0]  pat_sel,
  input  logic [15:0] vid_in_data,
  input  logic        vid_in_active,
  input  logic        vid_in_hsync,
  input  logic        vid_in_vsync,
  output logic [15:0] hdmi_out_data,
  output logic        hdmi_out_active,
  output logic        hdmi_out_hsync,
  output logic        hdmi_out_vsync,
  output logic        frame_start
);

  localparam int            HW    = $clog2(H_ACT + H_FP + H_SYNC + H_BP);
  localparam logic          POL   = SYNC_POL != 0;
  localparam logic [HW-1:0] BAR_W = HW'(H_ACT / 8);

  logic [1:0]    sel_s1_q, sel_s2_q;
  pat_e          mode_q, mode_d;
  logic [HW-1:0] h_cnt, bar_full;
  logic          gen_act, gen_hs, gen_vs, origin;
  logic [2:0]    bar_idx;
  ycc_t          bar;
  logic [7:0]    ramp_y;
  logic [15:0]   gen_data, data_d, data_q;
  logic          active_d, active_q, hsync_d, hsync_q, vsync_d, vsync_q, fs_q;

  hdmi_vtg #(
    .H_ACT(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACT(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .SYNC_POL(SYNC_POL), .HW(HW)
  ) u_vtg (
    .clk_i    (hdmi_clk),
    .rst_i    (hdmi_rst),
    .h_cnt_o  (h_cnt),
    .active_o (gen_act),
    .hsync_o  (gen_hs),
    .vsync_o  (gen_vs),
    .origin_o (origin)
  );

  // Synchroniser keeps sampling through reset so the first frame after release uses the current pat_sel
  always_ff @(posedge hdmi_clk) begin
    sel_s1_q <= pat_sel;
    sel_s2_q <= sel_s1_q;
  end

  always_comb begin
    mode_d   = origin ? pat_e'(sel_s2_q) : mode_q;
    bar_full = h_cnt / BAR_W;
    bar_idx  = (bar_full > HW'(7)) ? 3'd7 : bar_full[2:0];
    bar      = bar_ycc(bar_idx);
    ramp_y   = 8'd16 + 8'((16'(8'(h_cnt)) * 16'd219) >> 8);
    gen_data = !gen_act ? YCC_BLANK :
               mode_d == PAT_BARS ? {bar.y, h_cnt[0] ? bar.cr : bar.cb} :
               mode_d == PAT_RAMP ? {ramp_y, C_NEUTRAL} : YCC_WHITE;
    data_d   = mode_d == PAT_PASS ? vid_in_data   : gen_data;
    active_d = mode_d == PAT_PASS ? vid_in_active : gen_act;
    hsync_d  = mode_d == PAT_PASS ? vid_in_hsync  : gen_hs;
    vsync_d  = mode_d == PAT_PASS ? vid_in_vsync  : gen_vs;
  end

  always_ff @(posedge hdmi_clk or posedge hdmi_rst) begin
    if (hdmi_rst) begin
      mode_q   <= PAT_PASS;
      data_q   <= YCC_BLANK;
      active_q <= 1'b0;
      hsync_q  <= !POL;
      vsync_q  <= !POL;
      fs_q     <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      data_q   <= data_d;
      active_q <= active_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      fs_q     <= origin;
    end
  end

  assign hdmi_out_data   = data_q;
  assign hdmi_out_active = active_q;
  assign hdmi_out_hsync  = hsync_q;
  assign hdmi_out_vsync  = vsync_q;
  assign frame_start     = fs_q;

endmodule
